// File: rtl/lc3b_types.sv
// lc3b_types: shared word, MEM-stage state and byte-enable definitions for the lc3b pipeline.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, IND, ACC, DONE} lc3b_mem_state;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic indirect;
    logic byte_op;
  } lc3b_control_word_mem;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_LO = 2'b01;
endpackage

// File: rtl/mem_byte_align.sv
// mem_byte_align: word/byte alignment of address, enables, store data and zero-extended load data.
module mem_byte_align
  import lc3b_types::*;
(
  input  lc3b_word   base,
  input  logic       byte_op,
  input  lc3b_word   wdata_in,
  input  lc3b_word   rdata,
  output lc3b_word   address,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   load_data
);
  always_comb begin
    address = byte_op ? base : {base[15:1], 1'b0};
    byte_enable = !byte_op ? BE_WORD : base[0] ? BE_HI : BE_LO;
    wdata = byte_op ? {2{wdata_in[7:0]}} : wdata_in;
    load_data = !byte_op ? rdata : {8'h00, base[0] ? rdata[15:8] : rdata[7:0]};
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory sequencer for LDR/STR, LDB/STB and two-access LDI/STI.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             indirect,
  input  logic             byte_op,
  input  lc3b_word         mar_in,
  input  lc3b_word         mdr_in,
  output logic             dmem_read,
  output logic             dmem_write,
  output lc3b_word         dmem_address,
  output lc3b_word         dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  input  logic             dmem_resp,
  input  lc3b_word         dmem_rdata,
  output logic             stall,
  output lc3b_word         mem_data_out,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_count
);
  lc3b_control_word_mem ctrl;
  lc3b_mem_state state, next_state;
  lc3b_word ptr, base, load_data;
  logic op, acc_byte;
  assign ctrl = {mem_read, mem_write, indirect, byte_op};
  assign op = valid_in & (ctrl.mem_read | ctrl.mem_write);
  // The pointer fetch in IND is always an aligned word read of mar_in.
  assign base = (state == ACC && ctrl.indirect) ? ptr : mar_in;
  assign acc_byte = ctrl.byte_op & (state == ACC);
  mem_byte_align u_align (
    .base       (base),
    .byte_op    (acc_byte),
    .wdata_in   (mdr_in),
    .rdata      (dmem_rdata),
    .address    (dmem_address),
    .byte_enable(dmem_byte_enable),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );
  always_comb begin
    stall = (state == IDLE && op) || state == IND || state == ACC;
    dmem_read = state == IND || (state == ACC && ctrl.mem_read);
    dmem_write = state == ACC && ctrl.mem_write && !ctrl.mem_read;
    mem_done = state == DONE;
    next_state = state == IDLE ? (op ? (ctrl.indirect ? IND : ACC) : IDLE)
               : state == IND  ? (dmem_resp ? ACC : IND)
               : state == ACC  ? (dmem_resp ? DONE : ACC)
               : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      mem_data_out <= '0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      if (state == IND && dmem_resp) ptr <= dmem_rdata;
      if (state == ACC && dmem_resp && ctrl.mem_read) mem_data_out <= load_data;
      if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench with a responsive data-memory model and a 4-bit-counter twin.
module tb_mem_stage_ctrl;
  import lc3b_types::*;
  logic clk = 0, reset = 1, valid_in = 0, mem_read = 0, mem_write = 0, indirect = 0, byte_op = 0;
  logic dmem_resp = 0;
  logic [15:0] mar_in = 0, mdr_in = 0, dmem_rdata = 0;
  logic dmem_read, dmem_write, stall, mem_done;
  logic [15:0] dmem_address, dmem_wdata, mem_data_out, stall_count;
  logic [1:0] dmem_byte_enable;
  logic r4, w4, s4, d4;
  logic [15:0] a4, wd4, md4;
  logic [1:0] be4;
  logic [3:0] sc4;
  int errors = 0, checks = 0;
  int exp_count = 0;
  logic [15:0] exp_data = 0;
  typedef struct {
    logic rd;
    logic wr;
    logic [15:0] addr;
    logic [1:0] be;
    logic [15:0] wdata;
  } req_t;
  req_t req_q[$];
  logic [15:0] data_q[$];

  mem_stage_ctrl dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read(mem_read), .mem_write(mem_write),
    .indirect(indirect), .byte_op(byte_op), .mar_in(mar_in), .mdr_in(mdr_in),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .stall(stall), .mem_data_out(mem_data_out), .mem_done(mem_done),
    .stall_count(stall_count)
  );
  mem_stage_ctrl #(.CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read(mem_read), .mem_write(mem_write),
    .indirect(indirect), .byte_op(byte_op), .mar_in(mar_in), .mdr_in(mdr_in),
    .dmem_read(r4), .dmem_write(w4), .dmem_address(a4), .dmem_wdata(wd4),
    .dmem_byte_enable(be4), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .stall(s4),
    .mem_data_out(md4), .mem_done(d4), .stall_count(sc4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic run_op(input logic ind, input logic rd, input logic wr, input logic byt,
                        input logic [15:0] mar, input logic [15:0] mdr, input logic [15:0] r0,
                        input logic [15:0] r1, input int w0, input int w1);
    logic [15:0] base, rdl;
    logic [15:0] rdv[2];
    int waits[2];
    int acc = 0, wcnt = 0, stalls = 0, writes = 0, cyc = 0, exp_stall;
    bit done = 0;
    req_t e, got;
    waits = '{w0, w1};
    rdv = '{r0, r1};
    if (ind) req_q.push_back('{1'b1, 1'b0, {mar[15:1], 1'b0}, BE_WORD, 16'h0});
    base = ind ? r0 : mar;
    rdl = ind ? r1 : r0;
    e.rd = rd;
    e.wr = wr & ~rd;
    e.addr = byt ? base : {base[15:1], 1'b0};
    e.be = !byt ? BE_WORD : base[0] ? BE_HI : BE_LO;
    e.wdata = byt ? {mdr[7:0], mdr[7:0]} : mdr;
    req_q.push_back(e);
    if (rd) exp_data = !byt ? rdl : {8'h00, base[0] ? rdl[15:8] : rdl[7:0]};
    data_q.push_back(exp_data);
    exp_stall = ind ? 3 + w0 + w1 : 2 + w0;
    exp_count += exp_stall;
    @(posedge clk);
    #1;
    valid_in = 1; mem_read = rd; mem_write = wr; indirect = ind; byte_op = byt;
    mar_in = mar; mdr_in = mdr;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dmem_resp = 0;
      if (stall) stalls++;
      if (dmem_write) writes++;
      if (dmem_read || dmem_write) begin
        if (req_q.size() == 0) check("extra_request", 1, 0);
        else if (wcnt < waits[acc]) wcnt++;
        else begin
          got = req_q.pop_front();
          check("req_read", dmem_read, got.rd);
          check("req_write", dmem_write, got.wr);
          check("req_addr", dmem_address, got.addr);
          check("req_be", dmem_byte_enable, got.be);
          if (got.wr) check("req_wdata", dmem_wdata, got.wdata);
          dmem_resp = 1;
          dmem_rdata = rdv[acc];
          acc++;
          wcnt = 0;
        end
      end
      if (mem_done) begin
        if (data_q.size() == 0) check("extra_done", 1, 0);
        else check("load_data", mem_data_out, data_q.pop_front());
        done = 1;
        valid_in = 0;
      end
    end
    if (!done) check("timeout", 0, 1);
    check("stall_cycles", stalls, exp_stall);
    check("write_cycles", writes, (wr && !rd) ? 1 + (ind ? w1 : w0) : 0);
    @(negedge clk);
    dmem_resp = 0;
    check("done_pulse", mem_done, 0);
    check("idle_stall", stall, 0);
    check("stall_count", stall_count, exp_count);
    mem_read = 0; mem_write = 0; indirect = 0; byte_op = 0;
    req_q.delete();
    data_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_read", dmem_read, 0);
    check("rst_write", dmem_write, 0);
    check("rst_done", mem_done, 0);
    check("rst_data", mem_data_out, 0);
    check("rst_count", stall_count, 0);
    @(posedge clk);
    #1 reset = 0;
    run_op(0, 1, 0, 0, 16'h3005, 16'hFFFF, 16'hBEEF, 16'h0, 1, 0);
    run_op(0, 0, 1, 1, 16'h4001, 16'h12AB, 16'h0, 16'h0, 0, 0);
    run_op(1, 1, 0, 0, 16'h5000, 16'h0, 16'h6002, 16'h0F0F, 0, 0);
    run_op(0, 1, 0, 1, 16'h7003, 16'h0, 16'h9A34, 16'h0, 0, 0);
    run_op(0, 1, 0, 1, 16'h7002, 16'h0, 16'h9A34, 16'h0, 0, 0);
    run_op(0, 1, 1, 0, 16'h2000, 16'h5555, 16'h1234, 16'h0, 0, 0);
    run_op(0, 0, 1, 0, 16'h8001, 16'hCAFE, 16'h0, 16'h0, 2, 0);
    run_op(1, 1, 0, 0, 16'h5001, 16'h0, 16'h6003, 16'h8001, 1, 2);
    @(posedge clk);
    #1;
    valid_in = 0; mem_read = 1;
    repeat (3) begin
      @(negedge clk);
      check("inval_stall", stall, 0);
      check("inval_read", dmem_read, 0);
    end
    mem_read = 0;
    @(posedge clk);
    #1;
    valid_in = 1; mem_read = 1; mar_in = 16'h3005; dmem_resp = 0;
    for (int i = 0; i < 10 && !dmem_read; i++) @(negedge clk);
    check("acc_reached", dmem_read, 1);
    reset = 1;
    #1;
    check("abort_read", dmem_read, 0);
    check("abort_state", dut.state == IDLE, 1);
    check("abort_count", stall_count, 0);
    check("abort_data", mem_data_out, 0);
    check("abort_count4", sc4, 0);
    valid_in = 0; mem_read = 0;
    @(posedge clk);
    #1 reset = 0;
    exp_count = 0;
    exp_data = 0;
    run_op(0, 1, 0, 0, 16'h3000, 16'h0, 16'hA5A5, 16'h0, 20, 0);
    check("sat_count4", sc4, 4'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
